instruction_loader: RTL and testbench

- Writer side of the instruction memory that the fetch stage reads.
- Takes a byte stream from the UART receiver and assembles big-endian 32-bit instruction words.
- Writes the words to sequential word addresses starting at 0.
- Holds the CPU (fetch stall) while a program is being loaded. Releases it on a halt word or on memory full.

---
 rtl/instruction_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_instruction_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Writer side of the instruction memory read by the fetch stage. Bytes from
// the UART receiver are assembled into big-endian NB_DATA-bit words (first
// byte received lands in the MSB) and written to consecutive word addresses
// starting at 0. The CPU is held (fetch stall) while a program is loading and
// released when HALT_WORD has been written or the memory is full.
//
// Optional feature (macro LOADER_CHECKSUM_EN): an 8-bit running XOR of every
// received byte (halt word included) is compared against one trailer byte
// sent after HALT_WORD; a mismatch raises o_checksum_err. Without the macro
// o_checksum_err is tied low and HALT_WORD goes straight to DONE.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_rx_data      received byte, qualified by i_rx_valid
//   i_rx_valid     one-cycle strobe per received byte
//   i_start        one-cycle pulse that begins a load (IDLE or DONE only)
//   o_wr_en        memory write enable, one cycle per word
//   o_wr_addr      word address of the write
//   o_wr_data      word being written
//   o_cpu_hold     fetch stall request, high while loading
//   o_done         load finished (level)
//   o_overflow     memory filled before HALT_WORD arrived
//   o_word_count   words written in the current/last load
//   o_checksum_err trailer byte did not match the running XOR
// -----------------------------------------------------------------------------
module instruction_loader #(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 10,
    parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_start,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_cpu_hold,
    output logic               o_done,
    output logic               o_overflow,
    output logic [NB_ADDR:0]   o_word_count,
    output logic               o_checksum_err
);

    localparam int                 N_BYTES   = NB_DATA / NB_BYTE;
    localparam int                 NB_BCNT   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(N_BYTES - 1);
    localparam logic [NB_BCNT-1:0] BCNT_ONE  = NB_BCNT'(1'b1);
    localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};
    localparam logic [NB_ADDR-1:0] ADDR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};
    localparam logic [NB_ADDR:0]   WCNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    // Shift a new byte into the low end; older bytes move toward the MSB.
    function automatic logic [NB_DATA-1:0] shift_in(input logic [NB_DATA-1:0] word,
                                                    input logic [NB_BYTE-1:0] data);
        return {word[NB_DATA-NB_BYTE-1:0], data};
    endfunction

`ifdef LOADER_CHECKSUM_EN
    // Running XOR checksum over received bytes.
    function automatic logic [7:0] csum_update(input logic [7:0]         acc,
                                               input logic [NB_BYTE-1:0] data);
        return acc ^ 8'(data);
    endfunction
`endif

    state_t               state_r, state_s;
    logic [NB_DATA-1:0]   shift_r, shift_s;
    logic [NB_BCNT-1:0]   byte_cnt_r, byte_cnt_s;
    logic [NB_ADDR-1:0]   addr_r, addr_s;
    logic                 wr_en_r, wr_en_s;
    logic [NB_ADDR-1:0]   wr_addr_r, wr_addr_s;
    logic [NB_DATA-1:0]   wr_data_r, wr_data_s;
    logic                 hold_r, hold_s;
    logic                 done_r, done_s;
    logic                 ovf_r, ovf_s;
    logic [NB_ADDR:0]     wcnt_r, wcnt_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum_r, csum_s;
    logic                 csum_err_r, csum_err_s;
`endif

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and next-output logic; every output is registered.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        byte_cnt_s = byte_cnt_r;
        addr_s     = addr_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_data_s  = wr_data_r;
        hold_s     = hold_r;
        done_s     = done_r;
        ovf_s      = ovf_r;
        wcnt_s     = wcnt_r;
`ifdef LOADER_CHECKSUM_EN
        csum_s     = csum_r;
        csum_err_s = csum_err_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_s    = ST_RECV;
                    shift_s    = {NB_DATA{1'b0}};
                    byte_cnt_s = {NB_BCNT{1'b0}};
                    addr_s     = {NB_ADDR{1'b0}};
                    wcnt_s     = {(NB_ADDR+1){1'b0}};
                    ovf_s      = 1'b0;
                    hold_s     = 1'b1;
                    done_s     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_s     = 8'h00;
                    csum_err_s = 1'b0;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_RECV: begin
                if (i_rx_valid) begin
                    shift_s = shift_in(shift_r, i_rx_data);
`ifdef LOADER_CHECKSUM_EN
                    csum_s  = csum_update(csum_r, i_rx_data);
`endif
                    if (byte_cnt_r == LAST_BYTE) begin
                        // Word complete: present it on the write port next cycle.
                        byte_cnt_s = {NB_BCNT{1'b0}};
                        wr_en_s    = 1'b1;
                        wr_addr_s  = addr_r;
                        wr_data_s  = shift_s;
                        wcnt_s     = wcnt_r + WCNT_ONE;
                        state_s    = ST_WRITE;
                    end else begin
                        byte_cnt_s = byte_cnt_r + BCNT_ONE;
                    end
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (wr_data_r == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = ST_CHECK;
`else
                    state_s = ST_DONE;
                    hold_s  = 1'b0;
                    done_s  = 1'b1;
`endif
                end else if (addr_r == ADDR_LAST) begin
                    // Memory full without a halt word; address does not wrap.
                    state_s = ST_DONE;
                    ovf_s   = 1'b1;
                    hold_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    addr_s  = addr_r + ADDR_ONE;
                    state_s = ST_RECV;
                    // A byte arriving now is byte 0 of the next word.
                    if (i_rx_valid) begin
                        shift_s    = shift_in(shift_r, i_rx_data);
                        byte_cnt_s = BCNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                        csum_s     = csum_update(csum_r, i_rx_data);
`endif
                    end else begin
                        byte_cnt_s = {NB_BCNT{1'b0}};
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_valid) begin
                    csum_err_s = (8'(i_rx_data) != csum_r);
                    state_s    = ST_DONE;
                    hold_s     = 1'b0;
                    done_s     = 1'b1;
                end else begin
                    state_s = ST_CHECK;
                end
            end
`endif
            default: begin
                // Illegal encoding: fall back to a safe, released state.
                state_s = ST_IDLE;
                hold_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_r    <= {NB_DATA{1'b0}};
            byte_cnt_r <= {NB_BCNT{1'b0}};
            addr_r     <= {NB_ADDR{1'b0}};
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {NB_ADDR{1'b0}};
            wr_data_r  <= {NB_DATA{1'b0}};
            hold_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            wcnt_r     <= {(NB_ADDR+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= 8'h00;
            csum_err_r <= 1'b0;
`endif
        end else begin
            shift_r    <= shift_s;
            byte_cnt_r <= byte_cnt_s;
            addr_r     <= addr_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            hold_r     <= hold_s;
            done_r     <= done_s;
            ovf_r      <= ovf_s;
            wcnt_r     <= wcnt_s;
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= csum_s;
            csum_err_r <= csum_err_s;
`endif
        end
    end

    assign o_wr_en      = wr_en_r;
    assign o_wr_addr    = wr_addr_r;
    assign o_wr_data    = wr_data_r;
    assign o_cpu_hold   = hold_r;
    assign o_done       = done_r;
    assign o_overflow   = ovf_r;
    assign o_word_count = wcnt_r;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum_err = csum_err_r;
`else
    assign o_checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//
// Self-checking bench for instruction_loader. Expected writes are derived
// from the transmitted byte list: bytes are grouped four at a time into
// big-endian words, the list stops at the halt word or when memory is full.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

    localparam int          NB_DATA   = 32;
    localparam int          NB_BYTE   = 8;
    localparam int          NB_ADDR   = 10;
    localparam int          MEM_WORDS = 1 << NB_ADDR;
    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
`ifdef LOADER_CHECKSUM_EN
    localparam bit          CSUM_BUILD = 1'b1;
`else
    localparam bit          CSUM_BUILD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NB_BYTE-1:0] rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               start = 1'b0;
    logic               wr_en;
    logic [NB_ADDR-1:0] wr_addr;
    logic [NB_DATA-1:0] wr_data;
    logic               cpu_hold;
    logic               done;
    logic               overflow;
    logic [NB_ADDR:0]   word_count;
    logic               checksum_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;

    logic [7:0]         tx_q[$];
    logic [NB_ADDR-1:0] wa_q[$];
    logic [31:0]        wd_q[$];

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_word;
        int          exp_count;
    } vec_t;
    vec_t tbl[5];

    instruction_loader #(
        .NB_DATA  (NB_DATA),
        .NB_BYTE  (NB_BYTE),
        .NB_ADDR  (NB_ADDR),
        .HALT_WORD(HALT)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .i_start       (start),
        .o_wr_en       (wr_en),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_cpu_hold    (cpu_hold),
        .o_done        (done),
        .o_overflow    (overflow),
        .o_word_count  (word_count),
        .o_checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Record every memory write seen on the port.
    always @(negedge clk) begin
        if (rst_n && wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            last_wr_cyc = cyc;
            check("hold_during_write", cpu_hold, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_reached", done, 1);
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic build_random(input int nw);
        logic [31:0] w;
        tx_q.delete();
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0000_0000;
            push_word(w);
        end
        push_word(HALT);
    endtask

    // Load tx_q and compare every write and the final status against the model.
    task automatic run_load(input int maxgap, input int glitch_idx, input logic [7:0] trailer);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        logic [7:0]  x;
        bit          halt_seen;
        bit          exp_ovf;
        bit          exp_err;
        int          n;
        x = 8'h00;
        halt_seen = 1'b0;
        for (int i = 0; i + 3 < tx_q.size(); i += 4) begin
            w = {tx_q[i], tx_q[i+1], tx_q[i+2], tx_q[i+3]};
            exp_w.push_back(w);
            x = x ^ tx_q[i] ^ tx_q[i+1] ^ tx_q[i+2] ^ tx_q[i+3];
            if (w == HALT) begin
                halt_seen = 1'b1;
                break;
            end
            if (exp_w.size() == MEM_WORDS) break;
        end
        exp_ovf = !halt_seen && (exp_w.size() == MEM_WORDS);
        exp_err = CSUM_BUILD && halt_seen && (trailer != x);

        wa_q.delete();
        wd_q.delete();
        pulse_start();
        @(negedge clk);
        check("hold_after_start", cpu_hold, 1);
        check("done_cleared", done, 0);
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == glitch_idx) pulse_start();
            send_byte(tx_q[i], $urandom_range(0, maxgap));
        end
        if (CSUM_BUILD && halt_seen) send_byte(trailer, 2);
        wait_done();
        if (!(CSUM_BUILD && halt_seen))
            check("done_one_after_last_write", cyc - last_wr_cyc, 1);

        check("write_count", wd_q.size(), exp_w.size());
        n = (wd_q.size() < exp_w.size()) ? wd_q.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            check("wr_addr", wa_q[i], i);
            check("wr_data", wd_q[i], exp_w[i]);
        end
        check("word_count", word_count, exp_w.size());
        check("overflow", overflow, exp_ovf);
        check("hold_released", cpu_hold, 0);
        check("checksum_err", checksum_err, exp_err);
    endtask

    initial begin
        tbl[0] = '{8'h20, 8'h08, 8'h00, 8'h05, 32'h2008_0005, 2};
        tbl[1] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678, 2};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE, 2};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 2};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, done, overflow,
                                word_count, checksum_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bytes in IDLE are ignored.
        for (int k = 0; k < 3; k++) send_byte(8'hA5, 0);
        @(negedge clk);
        check("idle_no_write", wd_q.size(), 0);
        check("idle_hold", cpu_hold, 0);
        check("idle_done", done, 0);

        // Table of single-word programs followed by the halt word.
        for (int t = 0; t < 5; t++) begin
            tx_q.delete();
            tx_q.push_back(tbl[t].b0);
            tx_q.push_back(tbl[t].b1);
            tx_q.push_back(tbl[t].b2);
            tx_q.push_back(tbl[t].b3);
            if (tbl[t].exp_word != HALT) push_word(HALT);
            run_load(t % 2, -1, 8'h00);
            if (wd_q.size() > 0) check("tbl_word", wd_q[0], tbl[t].exp_word);
            else check("tbl_word_present", 0, 1);
            check("tbl_count", word_count, tbl[t].exp_count);
        end

        // Last byte strobe to write enable is one cycle; next byte lands in WRITE.
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        @(negedge clk);
        check("latency_wr_en", wr_en, 1);
        check("latency_wr_data", wr_data, 32'h2008_0005);
        check("latency_wr_addr", wr_addr, 0);
        for (int k = 0; k < 4; k++) send_byte(8'hFF, 0);
        if (CSUM_BUILD) send_byte(8'h2D, 2);
        wait_done();
        check("seq_writes", wd_q.size(), 2);
        if (wd_q.size() == 2) check("seq_halt_word", wd_q[1], HALT);
        check("seq_count", word_count, 2);
        check("seq_csum", checksum_err, 0);

        // Bytes in DONE are ignored.
        wd_q.delete();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 0);
        @(negedge clk);
        check("done_no_write", wd_q.size(), 0);
        check("done_held", done, 1);
        check("done_hold_low", cpu_hold, 0);
        check("done_count_kept", word_count, 2);

        // Randomised programs, some back-to-back, some with a start pulse mid-word.
        for (int r = 0; r < 6; r++) begin
            build_random($urandom_range(1, 12));
            run_load(r % 4, (r % 2 == 1) ? 6 : -1, 8'($urandom));
        end

        // Reset in the middle of a word.
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midload_reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, done, overflow,
                                        word_count, checksum_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_random(3);
        run_load(1, -1, 8'h00);

        // Fill memory without a halt word.
        tx_q.delete();
        for (int i = 0; i < MEM_WORDS; i++) push_word(32'($urandom) & 32'h7FFF_FFFF);
        run_load(0, -1, 8'h00);
        check("overflow_flag", overflow, 1);
        repeat (3) @(negedge clk);
        check("overflow_no_extra_write", wd_q.size(), MEM_WORDS);

`ifdef LOADER_CHECKSUM_EN
        tx_q.delete();
        push_word(32'h0102_0304);
        push_word(HALT);
        run_load(0, -1, 8'h04);
        check("csum_good", checksum_err, 0);
        run_load(1, -1, 8'h05);
        check("csum_bad", checksum_err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
